// File: rtl/handshake_elastic_buf.sv
// handshake_elastic_buf
//   DEPTH-entry elastic buffer between two valid/ready interfaces.
//   First-word-fall-through output, registered up_ready, one word per
//   cycle sustained throughput, occupancy count, almost-full flag and a
//   synchronous flush.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear; wins over push/pop in the same cycle
//   up_valid/up_data  upstream word offer
//   up_ready          registered "can accept" (no comb path from down_ready)
//   down_valid/_data  head of buffer (purely from registered state)
//   down_ready        downstream accept
//   count             words currently stored
//   almost_full       count >= AFULL_THRESH, registered alongside count
module handshake_elastic_buf #(
  parameter int WORD_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         up_valid,
  input  logic [WORD_WIDTH-1:0]        up_data,
  output logic                         up_ready,
  output logic                         down_valid,
  output logic [WORD_WIDTH-1:0]        down_data,
  input  logic                         down_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WORD_WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic                             push, pop;
  logic [CNT_W-1:0]                 next_count;

  assign push = up_valid & up_ready;
  assign pop  = down_valid & down_ready;

  // Output side reads only registered state, so nothing on up_* can reach
  // down_* within a cycle. The head slot is never the write target while
  // occupied (push requires count < DEPTH), which keeps down_data stable
  // during a downstream stall.
  assign down_valid = (count != '0);
  assign down_data  = mem[rd_ptr];

  always_comb begin
    next_count = count;
    if (flush)
      next_count = '0;
    else begin
      case ({push, pop})
        2'b10:   next_count = count + CNT_W'(1);
        2'b01:   next_count = count - CNT_W'(1);
        default: next_count = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      up_ready    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= next_count;
      // Ready and almost_full look at the post-update occupancy, so a pop
      // from full raises up_ready one cycle later (single bubble).
      up_ready    <= (next_count != CNT_W'(DEPTH));
      almost_full <= (next_count >= CNT_W'(AFULL_THRESH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= up_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);  // DEPTH is a power of two: natural wrap
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: doc/handshake_elastic_buf.md
Name: handshake_elastic_buf

Overview:
- Parametrised successor to the single-stage valid/ready handshake register: a DEPTH-entry elastic buffer between an upstream and a downstream valid/ready interface.
- Registered up_ready, first-word-fall-through output, full throughput of one word per cycle, occupancy count, almost-full flag and synchronous flush.
- Sits on any streaming datapath where producer and consumer stall independently and a single skid slot is not enough.

Parameters:
- WORD_WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all buffered words.
- up_valid  input  1  upstream word available.
- up_data  input  WORD_WIDTH  upstream word.
- up_ready  output  1  buffer can accept a word this cycle (registered).
- down_valid  output  1  buffer presents a word.
- down_data  output  WORD_WIDTH  word at head of buffer.
- down_ready  input  1  downstream accepts word this cycle.
- count  output  $clog2(DEPTH+1)  words currently stored.
- almost_full  output  1  count >= AFULL_THRESH (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, wr_ptr=rd_ptr=0, storage cleared to 0.
  - up_ready=0 while rst_n low; up_ready=1 on the first rising edge after release.
  - down_valid=0, down_data=0, almost_full=0.
- Handshake rules:
  - push = up_valid & up_ready; pop = down_valid & down_ready.
  - Transfer happens only on a clock edge where both signals are high.
- Push: writes up_data into mem[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: rd_ptr increments with the same wrap.
- count update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
- Output path:
  - down_valid = (count != 0); down_data = mem[rd_ptr].
  - No combinational path from up_* to down_*: a word pushed into an empty buffer appears on down_valid/down_data 1 cycle after the push edge.
- Stability: while down_valid=1 and down_ready=0, down_valid and down_data hold unchanged regardless of upstream activity.
- up_ready: registered; next value = (next_count != DEPTH). Upstream never sees a combinational path from down_ready.
- Full condition:
  - With count=DEPTH, up_ready=0 and no push is possible.
  - A pop while full raises up_ready on the following cycle. This is one bubble, accepted as the cost of the registered ready.
- Empty condition: down_valid=0 and down_ready is ignored; count never underflows.
- Throughput: with 0 < count < DEPTH and both sides active, one word per cycle in and out, and count stays constant.
- almost_full: registered from next_count, so it updates in the same cycle as count.
- flush:
  - Has priority over push and pop in the same cycle; any concurrent push or pop is discarded.
  - Next cycle: count=0, pointers=0, down_valid=0, up_ready=1, almost_full=0.
  - Storage contents need not be cleared.
- Reset mid-operation: all buffered data is lost immediately and outputs take reset values asynchronously.
- Ordering: strict FIFO; no word is duplicated or dropped except by flush or reset.

Test Plan:
- Single word (WORD_WIDTH=8, DEPTH=4, down_ready=1): push 0xA5 at edge N -> down_valid=1, down_data=0xA5 during cycle N+1; popped at edge N+1; count returns to 0.
- Fill and stall (down_ready=0, up_valid=1, data 0x01..0x06):
  - Accepts 0x01..0x04; up_ready=0 after the 4th push.
  - count=4; almost_full=1 from count=3.
  - down_data holds 0x01.
- Drain from full: raise down_ready for 1 cycle -> 0x01 popped, count=3, up_ready=1 next cycle, then 0x05 accepted. Output order continues 0x02, 0x03, 0x04, 0x05.
- Streaming: up_valid=down_ready=1 for 20 cycles with random data -> after the first-word latency, one word per cycle; count stays constant; output sequence equals input sequence.
- Flush with simultaneous push at count=3 -> next cycle count=0, down_valid=0, up_ready=1; the flushed and concurrently pushed words never appear at the output.
- Reset asserted at count=2, mid-clock -> down_valid=0, count=0, up_ready=0 immediately; up_ready=1 one edge after rst_n release; the next pushed word comes out first.
